// File: rtl/lift_ctrl_if.sv
// Request and status bundle between the button logic and the lift controller.
// The master side issues floor requests; the slave side reports car status.
interface lift_ctrl_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
);
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic [FLOOR_W-1:0] lift_floor;
  logic [1:0]         lift_state;
  logic [FLOORS-1:0]  pending;

  modport master (
    output req_valid, req_floor,
    input  lift_floor, lift_state, pending
  );

  modport slave (
    input  req_valid, req_floor,
    output lift_floor, lift_state, pending
  );
endinterface

// File: rtl/lift_ctrl.sv
// Single-car lift controller: latches floor requests and serves them in
// SCAN order, one floor per TRAVEL_CYC cycles, door open DOOR_CYC cycles.
module lift_ctrl #(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = 3,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic     clk,
  input  logic     rst,
  lift_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    DOOR = 2'b11
  } state_t;

  localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYC - 1);

  state_t             state;
  logic [FLOOR_W-1:0] floor;
  logic [FLOORS-1:0]  pend;
  logic               last_up;
  logic [TW-1:0]      t_cnt;
  logic [DW-1:0]      d_cnt;

  logic               req_ok;
  logic               req_here;
  logic [FLOORS-1:0]  set_mask;
  logic [FLOORS-1:0]  pend_set;
  logic [FLOOR_W-1:0] nf;
  logic [2:0]         cur;
  logic [2:0]         nxt;
  logic               up_pick;
  logic               fwd;
  logic               bwd;

  // {above, here, below} of floor f within mask p
  function automatic logic [2:0] scan(
    input logic [FLOORS-1:0]  p,
    input logic [FLOOR_W-1:0] f
  );
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(f))
        r[2] = r[2] | p[i];
      else if (i == int'(f))
        r[1] = r[1] | p[i];
      else
        r[0] = r[0] | p[i];
    end
    return r;
  endfunction

  always_comb begin
    req_ok   = bus.req_valid
             && (int'(bus.req_floor) < FLOORS);
    req_here = req_ok && (state == DOOR)
             && (bus.req_floor == floor);
    set_mask = '0;
    if (req_ok && !req_here)
      set_mask = FLOORS'(1) << bus.req_floor;
    pend_set = pend | set_mask;
    nf       = (state == UP) ? floor + FLOOR_W'(1)
                             : floor - FLOOR_W'(1);
    cur      = scan(pend, floor);
    nxt      = scan(pend, nf);
    up_pick  = cur[2] && (!cur[0] || last_up);
    fwd      = (state == UP) ? nxt[2] : nxt[0];
    bwd      = (state == UP) ? nxt[0] : nxt[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      floor   <= '0;
      pend    <= '0;
      last_up <= 1'b1;
      t_cnt   <= '0;
      d_cnt   <= '0;
    end else begin
      pend <= pend_set;
      unique case (state)
        IDLE: begin
          if (cur[1]) begin
            state <= DOOR;
            d_cnt <= '0;
            pend  <= pend_set & ~(FLOORS'(1) << floor);
          end else if (up_pick) begin
            state <= UP;
            t_cnt <= '0;
          end else if (cur[0]) begin
            state <= DOWN;
            t_cnt <= '0;
          end
        end
        UP, DOWN: begin
          if (t_cnt != T_LAST) begin
            t_cnt <= t_cnt + TW'(1);
          end else begin
            floor   <= nf;
            last_up <= (state == UP);
            t_cnt   <= '0;
            if (nxt[1]) begin
              state <= DOOR;
              d_cnt <= '0;
              pend  <= pend_set & ~(FLOORS'(1) << nf);
            end else if (!fwd) begin
              state <= bwd ? ((state == UP) ? DOWN : UP)
                           : IDLE;
            end
          end
        end
        DOOR: begin
          // a same-floor call keeps the door open instead of latching
          if (req_here) begin
            d_cnt <= '0;
          end else if (d_cnt != D_LAST) begin
            d_cnt <= d_cnt + DW'(1);
          end else begin
            t_cnt <= '0;
            if (up_pick)
              state <= UP;
            else if (cur[0])
              state <= DOWN;
            else
              state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.lift_floor = floor;
  assign bus.lift_state = state;
  assign bus.pending    = pend;

endmodule
